// File: rtl/dc_missq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dc_missq_pkg : shared types and encodings for the DC miss queue / fill stage
// Rev 1.0
// ----------------------------------------------------------------------------
package dc_missq_pkg;

  localparam int MISSQ_TAG_BITS   = 10;
  localparam int MISSQ_INDEX_BITS = 5;

  localparam logic [2:0] SC_CMD_REQ_S  = 3'd1;
  localparam logic [2:0] SC_CMD_REQ_M  = 3'd2;
  localparam logic [4:0] SC_SCMD_ACK_S = 5'd4;
  localparam logic [4:0] SC_SCMD_ACK_M = 5'd5;
  localparam logic [2:0] DC_STATE_S    = 3'd1;
  localparam logic [2:0] DC_STATE_M    = 3'd3;

  localparam logic [1:0] RRIP_INSERT  = 2'd2;
  localparam logic [1:0] RRIP_DISTANT = 2'd3;

  typedef enum logic [1:0] {
    E_FREE  = 2'd0,
    E_PEND  = 2'd1,
    E_SENT  = 2'd2,
    E_ACKED = 2'd3
  } entry_state_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RD   = 2'd1,
    F_SEL  = 2'd2,
    F_WR   = 2'd3
  } fill_state_e;

  typedef struct packed {
    entry_state_e                state;
    logic                        write;
    logic [MISSQ_TAG_BITS-1:0]   tag;
    logic [MISSQ_INDEX_BITS-1:0] index;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/dc_rrip_victim.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dc_rrip_victim : picks the lowest way whose RRIP counter is distant (3)
// Rev 1.0
// ----------------------------------------------------------------------------
module dc_rrip_victim
  import dc_missq_pkg::*;
#(
  parameter int WAYS = 8
) (
  input  logic [2*WAYS-1:0]       rrip,
  output logic                    found,
  output logic [$clog2(WAYS)-1:0] way
);

  localparam int WAY_W = $clog2(WAYS);

  // Scan from the top so the lowest matching way is the last one written.
  always_comb begin
    found = 1'b0;
    way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rrip[2*w +: 2] == RRIP_DISTANT) begin
        found = 1'b1;
        way   = WAY_W'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_1_missq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dc_1_missq : in-order L1 miss queue with RRIP victim fill into the tag bank
// Optional build macro DC_MISSQ_MERGE_EN absorbs duplicate misses.
// Rev 1.0
// ----------------------------------------------------------------------------
module dc_1_missq
  import dc_missq_pkg::*;
#(
  parameter int ENTRIES    = 4,
  parameter int TAG_BITS   = 10,
  parameter int INDEX_BITS = 5,
  parameter int WAYS       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss_valid,
  output logic                    miss_retry,
  input  logic                    miss_write,
  input  logic [TAG_BITS-1:0]     miss_tag,
  input  logic [INDEX_BITS-1:0]   miss_index,
  output logic                    l1tol2_req_valid,
  input  logic                    l1tol2_req_retry,
  output logic [2:0]              l1tol2_req,
  input  logic                    l2tol1_snack_valid,
  input  logic [4:0]              l2tol1_snack,
  output logic                    rrip_rd_valid,
  output logic [INDEX_BITS-1:0]   rrip_rd_index,
  input  logic [2*WAYS-1:0]       rrip_rd_data,
  output logic                    age_valid,
  output logic                    fill_valid,
  input  logic                    fill_retry,
  output logic [INDEX_BITS-1:0]   fill_index,
  output logic [$clog2(WAYS)-1:0] fill_way,
  output logic [TAG_BITS-1:0]     fill_tag,
  output logic [2:0]              fill_state,
  output logic [1:0]              fill_rrip,
  output logic                    err_unexp_ack
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int WAY_W = $clog2(WAYS);

  entry_t             r_q      [ENTRIES];
  logic               r_fill_m [ENTRIES];
  logic [PTR_W-1:0]   r_head, r_issue, r_ack, r_tail;
  logic [PTR_W:0]     r_count;
  logic               r_full, r_err;
  fill_state_e        r_fstate, w_fstate_nx;
  logic [1:0]         r_ages;
  logic [WAY_W-1:0]   r_victim;

  logic               w_dup_any, w_dup_block, w_absorb;
  logic               w_accept, w_req_valid, w_send;
  logic               w_ack_cmd, w_ack_ok, w_unexp, w_pop;
  logic               w_found;
  logic [WAY_W-1:0]   w_way;
  logic [PTR_W:0]     w_count_nx;
  entry_t             w_head;

  always_comb begin
    w_dup_any = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_q[i].state != E_FREE && r_q[i].tag == miss_tag && r_q[i].index == miss_index)
        w_dup_any = 1'b1;
    end
  end

`ifdef DC_MISSQ_MERGE_EN
  logic w_dup_s;
  always_comb begin
    w_dup_s = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_q[i].state != E_FREE && r_q[i].tag == miss_tag && r_q[i].index == miss_index
          && !r_q[i].write)
        w_dup_s = 1'b1;
    end
  end
  // A store cannot ride on a shared-only request; it must wait for that line to land.
  assign w_dup_block = miss_write & w_dup_s;
  assign w_absorb    = w_dup_any & ~w_dup_block;
`else
  assign w_dup_block = w_dup_any;
  assign w_absorb    = 1'b0;
`endif

  assign miss_retry  = ~reset | r_full | (miss_valid & w_dup_block);
  assign w_accept    = miss_valid & ~miss_retry & ~w_absorb;

  assign w_req_valid = (r_q[r_issue].state == E_PEND);
  assign w_send      = w_req_valid & ~l1tol2_req_retry;

  assign w_ack_cmd   = l2tol1_snack_valid &
                       ((l2tol1_snack == SC_SCMD_ACK_S) | (l2tol1_snack == SC_SCMD_ACK_M));
  assign w_ack_ok    = w_ack_cmd & (r_q[r_ack].state == E_SENT);
  assign w_unexp     = w_ack_cmd & ~w_ack_ok;
  assign w_pop       = (r_fstate == F_WR) & ~fill_retry;

  assign w_count_nx  = r_count + (PTR_W+1)'(w_accept) - (PTR_W+1)'(w_pop);
  assign w_head      = r_q[r_head];

  dc_rrip_victim #(.WAYS(WAYS)) u_victim (
    .rrip  (rrip_rd_data),
    .found (w_found),
    .way   (w_way)
  );

  // An ack landing on the head entry starts the read straight away.
  always_comb begin
    w_fstate_nx   = r_fstate;
    rrip_rd_valid = 1'b0;
    age_valid     = 1'b0;
    case (r_fstate)
      F_IDLE: if (w_head.state == E_ACKED || (w_ack_ok && r_ack == r_head)) w_fstate_nx = F_RD;
      F_RD: begin
        rrip_rd_valid = 1'b1;
        w_fstate_nx   = F_SEL;
      end
      F_SEL: begin
        if (w_found || r_ages == 2'd3) begin
          w_fstate_nx = F_WR;
        end else begin
          age_valid   = 1'b1;
          w_fstate_nx = F_RD;
        end
      end
      F_WR:    if (!fill_retry) w_fstate_nx = F_IDLE;
      default: w_fstate_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_q[i]      <= '0;
        r_fill_m[i] <= 1'b0;
      end
      r_head   <= '0;
      r_issue  <= '0;
      r_ack    <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
      r_fstate <= F_IDLE;
      r_ages   <= '0;
      r_victim <= '0;
    end else begin
      if (w_accept) begin
        r_q[r_tail] <= '{state: E_PEND, write: miss_write, tag: miss_tag, index: miss_index};
        r_tail      <= r_tail + 1'b1;
      end
      if (w_send) begin
        r_q[r_issue].state <= E_SENT;
        r_issue            <= r_issue + 1'b1;
      end
      if (w_ack_ok) begin
        r_q[r_ack].state <= E_ACKED;
        r_fill_m[r_ack]  <= (l2tol1_snack == SC_SCMD_ACK_M);
        r_ack            <= r_ack + 1'b1;
      end
      if (w_pop) begin
        r_q[r_head].state <= E_FREE;
        r_head            <= r_head + 1'b1;
      end
      if (w_unexp) r_err <= 1'b1;
      r_count  <= w_count_nx;
      r_full   <= (w_count_nx == (PTR_W+1)'(ENTRIES));
      r_fstate <= w_fstate_nx;
      if (r_fstate == F_IDLE)  r_ages <= '0;
      else if (age_valid)      r_ages <= r_ages + 1'b1;
      if (r_fstate == F_SEL)   r_victim <= w_way;
    end
  end

  assign l1tol2_req_valid = w_req_valid;
  assign l1tol2_req       = w_req_valid ? (r_q[r_issue].write ? SC_CMD_REQ_M : SC_CMD_REQ_S) : 3'd0;
  assign rrip_rd_index    = rrip_rd_valid ? w_head.index : '0;
  assign fill_valid       = (r_fstate == F_WR);
  assign fill_index       = (fill_valid | age_valid) ? w_head.index : '0;
  assign fill_way         = fill_valid ? r_victim : '0;
  assign fill_tag         = fill_valid ? w_head.tag : '0;
  assign fill_state       = fill_valid ? (r_fill_m[r_head] ? DC_STATE_M : DC_STATE_S) : 3'd0;
  assign fill_rrip        = fill_valid ? RRIP_INSERT : 2'd0;
  assign err_unexp_ack    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dc_1_missq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dc_1_missq : directed bench with a queue-level scoreboard and tag-bank RRIP model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dc_1_missq;
  import dc_missq_pkg::*;

  typedef struct { logic write; logic [9:0] tag; logic [4:0] index; } mreq_t;
  typedef struct { logic [4:0] index; logic [9:0] tag; logic [2:0] state; } fexp_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic        miss_valid = 1'b0, miss_write = 1'b0, miss_retry;
  logic [9:0]  miss_tag = '0;
  logic [4:0]  miss_index = '0;
  logic        l1tol2_req_valid, l1tol2_req_retry = 1'b0;
  logic [2:0]  l1tol2_req;
  logic        l2tol1_snack_valid = 1'b0;
  logic [4:0]  l2tol1_snack = '0;
  logic        rrip_rd_valid, age_valid, fill_valid, fill_retry = 1'b0, err_unexp_ack;
  logic [4:0]  rrip_rd_index, fill_index;
  logic [15:0] rrip_rd_data = '0;
  logic [2:0]  fill_way, fill_state;
  logic [9:0]  fill_tag;
  logic [1:0]  fill_rrip;

  dc_1_missq u_dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_write(miss_write),
    .miss_tag(miss_tag), .miss_index(miss_index),
    .l1tol2_req_valid(l1tol2_req_valid), .l1tol2_req_retry(l1tol2_req_retry), .l1tol2_req(l1tol2_req),
    .l2tol1_snack_valid(l2tol1_snack_valid), .l2tol1_snack(l2tol1_snack),
    .rrip_rd_valid(rrip_rd_valid), .rrip_rd_index(rrip_rd_index), .rrip_rd_data(rrip_rd_data),
    .age_valid(age_valid), .fill_valid(fill_valid), .fill_retry(fill_retry),
    .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .fill_state(fill_state), .fill_rrip(fill_rrip), .err_unexp_ack(err_unexp_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, req_count = 0;
  int fill_rise_cyc = 0, ack_cyc = 0, miss_cyc = 0, req_cyc = 0;
  int last_way = 0, last_ages = 0, ages_cur = 0, exp_ages = 0;
  logic [2:0]  last_state = '0;
  logic [15:0] model [32];
  mreq_t exp_req [$];
  mreq_t sent_q  [$];
  fexp_t exp_fill[$];
  mreq_t cmp_e;
  fexp_t cmp_f;
  bit    pv_req = 0, pv_fill = 0, rd_pend = 0, in_fill = 0;
  logic [2:0]  pv_req_cmd = '0;
  logic [22:0] pv_fill_flds = '0;
  logic [4:0]  rd_idx = '0;
  logic [15:0] tmp_v;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: observed 0x%0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  function automatic int lowest3(input logic [15:0] v);
    int r = -1;
    for (int w = 0; w < 8; w++) if (r < 0 && v[2*w +: 2] == 2'd3) r = w;
    return r;
  endfunction

  function automatic int max_ctr(input logic [15:0] v);
    int m = 0;
    for (int w = 0; w < 8; w++) if (int'(v[2*w +: 2]) > m) m = int'(v[2*w +: 2]);
    return m;
  endfunction

  function automatic logic [15:0] age_all(input logic [15:0] v);
    logic [15:0] r = v;
    for (int w = 0; w < 8; w++) if (r[2*w +: 2] != 2'd3) r[2*w +: 2] = r[2*w +: 2] + 2'd1;
    return r;
  endfunction

  // Tag bank: read data appears one cycle after the read strobe.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      rrip_rd_data = model[rd_idx];
      rd_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pv_req = 0; pv_fill = 0; rd_pend = 0; in_fill = 0;
    end else begin
      if (l1tol2_req_valid) begin
        if (pv_req) chk("req_stable", 64'(l1tol2_req), 64'(pv_req_cmd));
        if (!l1tol2_req_retry) begin
          req_count++;
          req_cyc = cyc;
          if (exp_req.size() == 0) note_fail("req_unexpected", 64'(l1tol2_req));
          else begin
            cmp_e = exp_req.pop_front();
            chk("req_cmd", 64'(l1tol2_req), 64'(cmp_e.write ? SC_CMD_REQ_M : SC_CMD_REQ_S));
            sent_q.push_back(cmp_e);
          end
        end
      end else if (pv_req) chk("req_held", 64'(l1tol2_req_valid), 64'(1));
      pv_req = l1tol2_req_valid && l1tol2_req_retry;
      pv_req_cmd = l1tol2_req;

      if (rrip_rd_valid) begin
        if (exp_fill.size() == 0) note_fail("rd_without_ack", 64'(rrip_rd_index));
        else begin
          chk("rd_index", 64'(rrip_rd_index), 64'(exp_fill[0].index));
          if (!in_fill) begin
            in_fill = 1; ages_cur = 0;
            exp_ages = 3 - max_ctr(model[rrip_rd_index]);
          end
        end
        rd_pend = 1;
        rd_idx = rrip_rd_index;
      end
      if (age_valid) begin
        ages_cur++;
        model[fill_index] = age_all(model[fill_index]);
      end

      if (fill_valid) begin
        if (!pv_fill) fill_rise_cyc = cyc;
        else chk("fill_stable", 64'({fill_index, fill_way, fill_tag, fill_state, fill_rrip}), 64'(pv_fill_flds));
        if (!fill_retry) begin
          if (exp_fill.size() == 0) note_fail("fill_unexpected", 64'(fill_tag));
          else begin
            cmp_f = exp_fill.pop_front();
            chk("fill_index", 64'(fill_index), 64'(cmp_f.index));
            chk("fill_tag",   64'(fill_tag),   64'(cmp_f.tag));
            chk("fill_state", 64'(fill_state), 64'(cmp_f.state));
            chk("fill_rrip",  64'(fill_rrip),  64'(2));
            chk("fill_way",   64'(fill_way),   64'(lowest3(model[fill_index])));
            chk("fill_ages",  64'(ages_cur),   64'(exp_ages));
            last_way = int'(fill_way); last_state = fill_state; last_ages = ages_cur;
            tmp_v = model[fill_index];
            tmp_v[2*fill_way +: 2] = 2'd2;
            model[fill_index] = tmp_v;
            in_fill = 0;
          end
        end
      end else if (pv_fill) chk("fill_held", 64'(fill_valid), 64'(1));
      pv_fill = fill_valid && fill_retry;
      pv_fill_flds = {fill_index, fill_way, fill_tag, fill_state, fill_rrip};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic w, input logic [9:0] tag, input logic [4:0] idx,
                         input logic exp_retry, input logic exp_new);
    miss_valid = 1; miss_write = w; miss_tag = tag; miss_index = idx;
    miss_cyc = cyc;
    @(negedge clk);
    chk("miss_retry", 64'(miss_retry), 64'(exp_retry));
    if (!exp_retry && exp_new) exp_req.push_back('{write: w, tag: tag, index: idx});
    @(posedge clk); #1;
    miss_valid = 0;
  endtask

  task automatic ack(input logic m);
    l2tol1_snack_valid = 1;
    l2tol1_snack = m ? SC_SCMD_ACK_M : SC_SCMD_ACK_S;
    ack_cyc = cyc;
    if (sent_q.size() > 0) begin
      cmp_e = sent_q.pop_front();
      exp_fill.push_back('{index: cmp_e.index, tag: cmp_e.tag, state: m ? DC_STATE_M : DC_STATE_S});
    end
    tick(1);
    l2tol1_snack_valid = 0;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (sent_q.size() < n && k < 100) begin tick(1); k++; end
    if (k >= 100) note_fail("timeout_wait_sent", 64'(sent_q.size()));
  endtask

  task automatic wait_fills_done();
    int k = 0;
    while (exp_fill.size() != 0 && k < 300) begin tick(1); k++; end
    if (k >= 300) note_fail("timeout_wait_fill", 64'(exp_fill.size()));
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, k;
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[5] = 16'hFFFF; model[9] = 16'hAAAA; model[7] = 16'hFFFF; model[12] = 16'hFFFF;
    model[1] = 16'h00C0; model[2] = 16'h0000; model[3] = 16'h5555; model[4] = 16'h3000;

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_miss_retry", 64'(miss_retry), 64'(1));
    chk("rst_outputs", 64'({l1tol2_req_valid, l1tol2_req, rrip_rd_valid, rrip_rd_index, age_valid,
        fill_valid, fill_index, fill_way, fill_tag, fill_state, fill_rrip, err_unexp_ack}), 64'(0));
    reset = 1;
    tick(2);
    chk("post_rst_retry", 64'(miss_retry), 64'(0));

    // 1: load miss, all-distant set -> way0 shared, fill 3 cycles after ack
    do_miss(0, 10'h3A1, 5'd5, 0, 1);
    wait_sent(1);
    chk("t1_issue_latency", 64'(req_cyc - miss_cyc), 64'(1));
    ack(0);
    wait_fills_done();
    chk("t1_fill_latency", 64'(fill_rise_cyc - ack_cyc), 64'(3));
    chk("t1_way", 64'(last_way), 64'(0));
    chk("t1_state", 64'(last_state), 64'(DC_STATE_S));

    // 2: store miss, all counters 2 -> one age then way0 modified
    do_miss(1, 10'h155, 5'd9, 0, 1);
    wait_sent(1);
    ack(1);
    wait_fills_done();
    chk("t2_ages", 64'(last_ages), 64'(1));
    chk("t2_way", 64'(last_way), 64'(0));
    chk("t2_state", 64'(last_state), 64'(DC_STATE_M));

    // 3: fill the queue under L2 back-pressure, then drain
    l1tol2_req_retry = 1;
    do_miss(0, 10'h101, 5'd1, 0, 1);
    do_miss(1, 10'h102, 5'd2, 0, 1);
    do_miss(0, 10'h103, 5'd3, 0, 1);
    do_miss(1, 10'h104, 5'd4, 0, 1);
    do_miss(0, 10'h105, 5'd6, 1, 0);
    tick(3);
    chk("t3_req_pending", 64'(l1tol2_req_valid), 64'(1));
    l1tol2_req_retry = 0;
    wait_sent(4);
    chk("t3_full_retry", 64'(miss_retry), 64'(1));
    ack(0); ack(1); ack(1); ack(0);
    wait_fills_done();
    chk("t3_retry_drops", 64'(miss_retry), 64'(0));
    chk("t3_last_way", 64'(last_way), 64'(6));

    // 4: duplicate load of a pending line
    base = req_count;
    do_miss(0, 10'h055, 5'd7, 0, 1);
    wait_sent(1);
`ifdef DC_MISSQ_MERGE_EN
    do_miss(0, 10'h055, 5'd7, 0, 0);
    do_miss(1, 10'h055, 5'd7, 1, 0);
    ack(0);
    wait_fills_done();
    chk("t4_reqs", 64'(req_count - base), 64'(1));
`else
    do_miss(0, 10'h055, 5'd7, 1, 0);
    do_miss(0, 10'h055, 5'd7, 1, 0);
    do_miss(0, 10'h055, 5'd7, 1, 0);
    ack(0);
    wait_fills_done();
    do_miss(0, 10'h055, 5'd7, 0, 1);
    wait_sent(1);
    ack(0);
    wait_fills_done();
    chk("t4_reqs", 64'(req_count - base), 64'(2));
`endif

    // 5: unexpected ack on an empty queue
    chk("t5_err_clear", 64'(err_unexp_ack), 64'(0));
    ack(0);
    tick(2);
    chk("t5_err_set", 64'(err_unexp_ack), 64'(1));
    tick(3);
    chk("t5_err_sticky", 64'(err_unexp_ack), 64'(1));

    // 6: reset while a fill is stalled
    fill_retry = 1;
    do_miss(1, 10'h2C3, 5'd12, 0, 1);
    wait_sent(1);
    ack(1);
    k = 0;
    while (!fill_valid && k < 20) begin tick(1); k++; end
    if (k >= 20) note_fail("timeout_t6_fill", 64'(k));
    tick(1);
    #2 reset = 0;
    #1;
    chk("t6_fill_drop", 64'(fill_valid), 64'(0));
    chk("t6_retry_in_rst", 64'(miss_retry), 64'(1));
    chk("t6_req_in_rst", 64'(l1tol2_req_valid), 64'(0));
    exp_fill.delete(); sent_q.delete(); exp_req.delete();
    repeat (2) @(posedge clk); #1;
    fill_retry = 0;
    reset = 1;
    tick(2);
    chk("t6_no_fill", 64'(fill_valid), 64'(0));
    chk("t6_retry_low", 64'(miss_retry), 64'(0));
    chk("t6_err_cleared", 64'(err_unexp_ack), 64'(0));
    do_miss(0, 10'h2C3, 5'd12, 0, 1);
    wait_sent(1);
    ack(0);
    wait_fills_done();
    chk("t6_refill_state", 64'(last_state), 64'(DC_STATE_S));

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
